irq_controller: RTL

- Parametrised interrupt controller between on-board event sources (PS/2 key-press edge, JTAG UART, timer) and the riscv64 core.
- Generalises the single-source key-press vector/done latch to NUM_SRC sources with per-source enable, edge/level mode, fixed priority, a claim/complete handshake and a bus-mapped register file.
- Sits on the 64-bit CPU bus; the top-level decoder asserts bus_select for its window.

---
 rtl/irq_controller.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// Prioritised interrupt controller with claim/complete handshake
// and a small bus-mapped register file on the 64-bit CPU bus.
module irq_controller #(
   parameter int                 NUM_SRC     = 8,
   parameter int                 VEC_W       = 5,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [NUM_SRC-1:0] EDGE_RESET  = '1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   output logic [VEC_W-1:0]   interrupt_vector,
   output logic               irq,
   input  logic               interrupt_ack,
   input  logic               interrupt_done,
   input  logic               bus_select,
   input  logic [63:0]        bus_address,
   input  logic [63:0]        bus_write_data,
   input  logic               bus_write_enable,
   input  logic               bus_read_enable,
   output logic [63:0]        bus_read_data
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      BUSY    = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [VEC_W-1:0]   r_cur_id;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_enable;
   logic [NUM_SRC-1:0] r_edge;
   logic [NUM_SRC-1:0] r_s_d;
   logic [63:0]        r_rdata;

   logic [NUM_SRC-1:0] w_s;
   logic [NUM_SRC-1:0] w_rise;
   logic [NUM_SRC-1:0] w_req;
   logic [NUM_SRC-1:0] w_cur_mask;
   logic [NUM_SRC-1:0] w_wdata;
   logic [NUM_SRC-1:0] w_mode_chg;
   logic [NUM_SRC-1:0] w_w1c;
   logic [NUM_SRC-1:0] w_cclr;
   logic [NUM_SRC-1:0] w_pend_nxt;
   logic [VEC_W-1:0]   w_win;
   logic [VEC_W-1:0]   w_vec_p1;
   logic [2:0]         w_off;
   logic               w_wr;
   logic               w_rd;
   logic               w_claim_rd;
   logic               w_claim;
   logic               w_done;
   logic               w_any;
   logic               w_cur_live;
   logic [63:0]        w_rdata;
   logic               w_unused;

   // Only address bits [5:3] select a register
   assign w_unused = ^{bus_address[63:6], bus_address[2:0]};

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_s = irq_src;
      end else begin : g_sync
         logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
         // Synchronise raw requests into the clk domain
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int k = 0; k < SYNC_STAGES; k++)
                  r_sync[k] <= '0;
            end else begin
               r_sync[0] <= irq_src;
               for (int k = 1; k < SYNC_STAGES; k++)
                  r_sync[k] <= r_sync[k-1];
            end
         end
         assign w_s = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   assign w_off      = bus_address[5:3];
   assign w_wr       = bus_select & bus_write_enable;
   assign w_rd       = bus_select & bus_read_enable;
   assign w_wdata    = bus_write_data[NUM_SRC-1:0];
   assign w_rise     = w_s & ~r_s_d;
   assign w_req      = r_pending & r_enable;
   assign w_any      = |w_req;
   assign w_cur_mask = NUM_SRC'(1) << r_cur_id;
   assign w_cur_live = |(w_cur_mask & w_req);
   assign w_vec_p1   = r_cur_id + 1'b1;

   // A CLAIM read and an ack in the same cycle form a single claim
   assign w_claim_rd = w_rd & (w_off == 3'd3);
   assign w_claim    = (r_state == PRESENT) &
                       (interrupt_ack | w_claim_rd);
   assign w_done     = (r_state == BUSY) &
                       (interrupt_done |
                        (w_wr & (w_off == 3'd3) &
                         (bus_write_data == 64'(w_vec_p1))));

   assign w_mode_chg = (w_wr && w_off == 3'd2) ?
                       (r_edge ^ w_wdata) : '0;
   assign w_w1c      = (w_wr && w_off == 3'd0) ?
                       (w_wdata & r_edge) : '0;
   assign w_cclr     = w_claim ? (w_cur_mask & r_edge) : '0;
   // Edge bits: clears first, then a new edge sets (set wins)
   assign w_pend_nxt = ~w_mode_chg &
                       ((r_edge & ((r_pending & ~w_w1c & ~w_cclr)
                                   | w_rise)) |
                        (~r_edge & w_s));

   // Fixed priority: lowest requesting index wins
   always_comb begin
      w_win = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (w_req[i]) w_win = VEC_W'(i);
   end

   // Register file, edge history and latched winner
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending <= '0;
         r_enable  <= '0;
         r_edge    <= EDGE_RESET;
         r_s_d     <= '0;
         r_cur_id  <= '0;
      end else begin
         r_pending <= w_pend_nxt;
         r_s_d     <= w_s;
         if (w_wr && w_off == 3'd1) r_enable <= w_wdata;
         if (w_wr && w_off == 3'd2) r_edge   <= w_wdata;
         if (r_state == IDLE && w_any) r_cur_id <= w_win;
      end
   end

   // Read data mux
   always_comb begin
      w_rdata = '0;
      case (w_off)
         3'd0: w_rdata[NUM_SRC-1:0] = r_pending;
         3'd1: w_rdata[NUM_SRC-1:0] = r_enable;
         3'd2: w_rdata[NUM_SRC-1:0] = r_edge;
         3'd3: w_rdata[VEC_W-1:0]   =
                  (r_state == PRESENT) ? w_vec_p1 : '0;
         3'd4: begin
            w_rdata[9:8]       = r_state;
            w_rdata[VEC_W-1:0] = r_cur_id;
         end
         default: w_rdata = '0;
      endcase
   end

   // Registered read port, holds until the next read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    r_rdata <= '0;
      else if (w_rd) r_rdata <= w_rdata;
   end

   assign bus_read_data = r_rdata;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any) w_state_nxt = PRESENT;
         PRESENT: begin
            if (w_claim)          w_state_nxt = BUSY;
            else if (!w_cur_live) w_state_nxt = IDLE;
         end
         BUSY:    if (w_done) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      interrupt_vector = '0;
      irq              = 1'b0;
      if (r_state == PRESENT) begin
         interrupt_vector = w_vec_p1;
         irq              = 1'b1;
      end
   end

endmodule
